// File: rtl/sargantana_icache_pkg.sv
// Shared types, constants and helpers for the instruction-cache replacement logic.
package sargantana_icache_pkg;

   // Replacement policy selector values
   typedef enum logic [1:0] {
      PolicyPlru       = 2'd0,
      PolicyLfsr       = 2'd1,
      PolicyRoundRobin = 2'd2
   } repl_policy_e;

   localparam int unsigned DefaultNWays = 4;
   localparam int unsigned DefaultNSets = 64;

   // Fibonacci LFSR, taps 16,14,13,11 (bit positions 15,13,12,10)
   localparam int unsigned LfsrWidth       = 16;
   localparam logic [15:0] LfsrTaps        = 16'hB400;
   localparam logic [15:0] DefaultLfsrSeed = 16'hACE1;

   // One LFSR step: shift left, feedback enters at bit 0
   function automatic logic [15:0] lfsr_step(input logic [15:0] state);
      return {state[14:0], ^(state & LfsrTaps)};
   endfunction

endpackage

// File: rtl/sargantana_icache_plru_tree.sv
// Tree pseudo-LRU for one set: victim decode and touch update.
// Nodes are heap-ordered (children of node n are 2n+1 and 2n+2); a node bit of
// 0 steers the victim search to the lower half, 1 to the upper half.
module sargantana_icache_plru_tree #(
   parameter int unsigned N_WAYS = 4
) (
   input  logic [N_WAYS-2:0]         bits_i,
   input  logic [$clog2(N_WAYS)-1:0] touch_way_i,
   output logic [$clog2(N_WAYS)-1:0] victim_o,
   output logic [N_WAYS-2:0]         bits_o
);

   localparam int unsigned WayW   = $clog2(N_WAYS);
   localparam int unsigned NNodes = N_WAYS - 1;

   // Walk from the root following the node bits to the pseudo-LRU way
   always_comb begin
      int unsigned       prefix;
      int unsigned       node;
      logic [NNodes-1:0] shifted;
      prefix  = 0;
      node    = 0;
      shifted = '0;
      for (int unsigned l = 0; l < WayW; l++) begin
         node    = (32'd1 << l) - 32'd1 + prefix;
         shifted = bits_i >> node;
         prefix  = (prefix << 1) | {31'd0, shifted[0]};
      end
      victim_o = WayW'(prefix);
   end

   // Point every node on the touched way's path away from it
   always_comb begin
      int unsigned       node;
      int unsigned       way;
      logic [NNodes-1:0] mask;
      bits_o = bits_i;
      node   = 0;
      mask   = '0;
      way    = 32'(touch_way_i);
      for (int unsigned l = 0; l < WayW; l++) begin
         node = (32'd1 << l) - 32'd1 + (way >> (WayW - l));
         mask = NNodes'(1) << node;
         if (((way >> (WayW - 1 - l)) & 32'd1) != 0) begin
            bits_o = bits_o & ~mask;
         end else begin
            bits_o = bits_o | mask;
         end
      end
   end

endmodule

// File: rtl/sargantana_icache_repl_policy_unit.sv
// Instruction-cache way replacement unit: victim selection (invalid-first, then
// PLRU / LFSR / round-robin among unlocked ways), refill write strobes and a
// whole-cache invalidation walk.
module sargantana_icache_repl_policy_unit
   import sargantana_icache_pkg::*;
#(
   parameter int unsigned N_WAYS    = DefaultNWays,
   parameter int unsigned N_SETS    = DefaultNSets,
   parameter int unsigned POLICY    = 0,
   parameter logic [15:0] LFSR_SEED = DefaultLfsrSeed,
   localparam int unsigned WayW     = $clog2(N_WAYS),
   localparam int unsigned SetW     = $clog2(N_SETS)
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              flush_i,
   input  logic              rd_ena_i,
   input  logic              wr_ena_i,
   input  logic              miss_i,
   input  logic              hit_i,
   input  logic [SetW-1:0]   set_idx_i,
   input  logic [WayW-1:0]   hit_way_i,
   input  logic [N_WAYS-1:0] way_valid_bits_i,
   input  logic [N_WAYS-1:0] lock_mask_i,
   output logic [WayW-1:0]   victim_way_o,
   output logic              victim_ok_o,
   output logic              we_valid_o,
   output logic              valid_wdata_o,
   output logic [SetW-1:0]   addr_valid_o,
   output logic [N_WAYS-1:0] tag_req_valid_o,
   output logic [N_WAYS-1:0] data_req_valid_o,
   output logic              busy_o
);

   typedef enum logic {
      StIdle,
      StFlush
   } state_e;

   state_e          state_q;
   logic [SetW-1:0] cnt_q;
   logic            busy_q;
   logic [WayW-1:0] victim_q;
   logic            victim_ok_q;

   logic            idle;
   logic            refill_go;
   logic [WayW-1:0] pol_cand;
   logic [WayW-1:0] sel_way;
   logic            sel_ok;
   logic [WayW-1:0] probe;
   logic [N_WAYS-1:0] victim_oh;

   assign idle      = (state_q == StIdle);
   // A refill only counts when a usable victim was latched
   assign refill_go = idle & wr_ena_i & victim_ok_q;
   assign victim_oh = N_WAYS'(1) << victim_q;

   // Policy state and candidate way for the addressed set
   if (POLICY == int'(PolicyPlru)) begin : g_plru
      logic [N_WAYS-2:0] plru_q [N_SETS];
      logic [N_WAYS-2:0] cur_bits;
      logic [N_WAYS-2:0] upd_bits;
      logic [WayW-1:0]   touch_way;
      logic              hit_go;

      assign hit_go    = idle & hit_i;
      assign cur_bits  = plru_q[set_idx_i];
      // Refill wins over a simultaneous hit on the same set
      assign touch_way = refill_go ? victim_q : hit_way_i;

      sargantana_icache_plru_tree #(
         .N_WAYS(N_WAYS)
      ) u_plru_tree (
         .bits_i     (cur_bits),
         .touch_way_i(touch_way),
         .victim_o   (pol_cand),
         .bits_o     (upd_bits)
      );

      // Flush clears one set per cycle; in idle, refills and hits retrain the set
      always_ff @(posedge clk_i or negedge rstn_i) begin
         if (!rstn_i) begin
            for (int s = 0; s < N_SETS; s++) begin
               plru_q[s] <= '0;
            end
         end else if (!idle) begin
            plru_q[cnt_q] <= '0;
         end else if (refill_go || hit_go) begin
            plru_q[set_idx_i] <= upd_bits;
         end
      end
   end else if (POLICY == int'(PolicyLfsr)) begin : g_lfsr
      logic [LfsrWidth-1:0] lfsr_q;
      logic                 unused_hit;

      assign unused_hit = hit_i ^ (^hit_way_i);
      assign pol_cand   = lfsr_q[WayW-1:0];

      // Advance only on refills into a full set
      always_ff @(posedge clk_i or negedge rstn_i) begin
         if (!rstn_i) begin
            lfsr_q <= LFSR_SEED;
         end else if (idle && wr_ena_i && (&way_valid_bits_i)) begin
            lfsr_q <= lfsr_step(lfsr_q);
         end
      end
   end else begin : g_rr
      logic [WayW-1:0] rr_q [N_SETS];
      logic            unused_hit;

      assign unused_hit = hit_i ^ (^hit_way_i);
      assign pol_cand   = rr_q[set_idx_i];

      // Pointer moves past the way just refilled, wrapping naturally
      always_ff @(posedge clk_i or negedge rstn_i) begin
         if (!rstn_i) begin
            for (int s = 0; s < N_SETS; s++) begin
               rr_q[s] <= '0;
            end
         end else if (!idle) begin
            rr_q[cnt_q] <= '0;
         end else if (refill_go) begin
            rr_q[set_idx_i] <= victim_q + WayW'(1);
         end
      end
   end

   // Victim choice: lowest free unlocked way, else first unlocked from the candidate up
   always_comb begin
      sel_way = pol_cand;
      sel_ok  = 1'b0;
      probe   = '0;
      for (int i = 0; i < N_WAYS; i++) begin
         if (!sel_ok && !way_valid_bits_i[i] && !lock_mask_i[i]) begin
            sel_way = WayW'(i);
            sel_ok  = 1'b1;
         end
      end
      for (int i = 0; i < N_WAYS; i++) begin
         probe = pol_cand + WayW'(i);
         if (!sel_ok && !lock_mask_i[probe]) begin
            sel_way = probe;
            sel_ok  = 1'b1;
         end
      end
   end

   // Victim latch on a lookup miss
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         victim_q    <= '0;
         victim_ok_q <= 1'b0;
      end else if (idle && miss_i) begin
         victim_q    <= sel_way;
         victim_ok_q <= sel_ok;
      end
   end

   // Flush-walk FSM with registered busy flag
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (flush_i) begin
                  state_q <= StFlush;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            StFlush: begin
               if (cnt_q == SetW'(N_SETS - 1)) begin
                  state_q <= StIdle;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + SetW'(1);
               end
            end
         endcase
      end
   end

   // RAM strobes: flush walk, else refill write with read enables taking priority
   always_comb begin
      we_valid_o       = 1'b0;
      valid_wdata_o    = 1'b0;
      addr_valid_o     = set_idx_i;
      tag_req_valid_o  = '0;
      data_req_valid_o = '0;
      if (!idle) begin
         we_valid_o      = 1'b1;
         addr_valid_o    = cnt_q;
         tag_req_valid_o = '1;
      end else begin
         if (refill_go) begin
            we_valid_o       = 1'b1;
            valid_wdata_o    = 1'b1;
            tag_req_valid_o  = victim_oh;
            data_req_valid_o = victim_oh;
         end
         if (rd_ena_i) begin
            tag_req_valid_o  = '1;
            data_req_valid_o = '1;
         end
      end
   end

   assign victim_way_o = victim_q;
   assign victim_ok_o  = victim_ok_q;
   assign busy_o       = busy_q;

endmodule
